systolic_result_collector: RTL and testbench

SYSTOLIC_RESULT_COLLECTOR -- requirements
Module: systolic_result_collector

---
 rtl/systolic_result_collector_pkg.sv | 14 +
 rtl/systolic_result_collector_row_counter.sv | 21 ++
 rtl/systolic_result_collector.sv | 134 +++++++++++++
 tb/tb_systolic_result_collector.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_collector_pkg.sv
// Shared sizing and state encoding for the systolic array drain path.
// The array controller imports the same state encoding.
package systolic_result_collector_pkg;

  localparam int N   = 32;
  localparam int DIM = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    OUTPUT  = 2'b10
  } state_t;

endpackage

// File: rtl/systolic_result_collector_row_counter.sv
// Row index for capture and output. Single cycle; clr and load_zero win over enable.
// Saturates at MAX so the index can never run past the last buffer row.
module collector_row_counter #(
  parameter logic [2:0] MAX = 3'(systolic_result_collector_pkg::DIM - 1)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       load_zero,
  output logic [2:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr || load_zero) begin
      cnt <= 3'd0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Captures DIM bottom-row words (last row first) then presents rows 0..DIM-1 with valid/ready.
// First row valid the edge after the last capture; rows hold stable while res_ready is low.
module systolic_result_collector #(
  parameter int N   = systolic_result_collector_pkg::N,
  parameter int DIM = systolic_result_collector_pkg::DIM
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         drain_start,
  input  logic [N-1:0] col_in0,
  input  logic [N-1:0] col_in1,
  input  logic [N-1:0] col_in2,
  input  logic [N-1:0] col_in3,
  input  logic [N-1:0] col_in4,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [2:0]   res_row,
  output logic [N-1:0] res0,
  output logic [N-1:0] res1,
  output logic [N-1:0] res2,
  output logic [N-1:0] res3,
  output logic [N-1:0] res4,
  output logic         busy,
  output logic         overrun
);

  import systolic_result_collector_pkg::*;

  localparam logic [2:0] LAST = 3'(DIM - 1);

  state_t       state;
  logic [2:0]   cnt;
  logic [2:0]   nxt;
  logic         hs;
  logic         last_hs;
  logic         cnt_en;
  logic         cnt_zero;
  logic [N-1:0] col_w   [5];
  logic [N-1:0] res_q   [5];
  logic [N-1:0] row_buf [DIM][5];

  assign col_w[0] = col_in0;
  assign col_w[1] = col_in1;
  assign col_w[2] = col_in2;
  assign col_w[3] = col_in3;
  assign col_w[4] = col_in4;

  assign res0 = res_q[0];
  assign res1 = res_q[1];
  assign res2 = res_q[2];
  assign res3 = res_q[3];
  assign res4 = res_q[4];

  assign hs      = (state == OUTPUT) && res_ready;
  assign last_hs = hs && (cnt == LAST);
  assign nxt     = cnt + 3'd1;

  // The same counter walks capture rows and then output rows; it is zeroed at each phase change.
  assign cnt_en   = ((state == CAPTURE) || hs) && (cnt != LAST);
  assign cnt_zero = (state == IDLE) || ((state == CAPTURE) && (cnt == LAST)) || last_hs;

  collector_row_counter #(.MAX(LAST)) u_row_counter (
    .clk       (clk),
    .clr       (clr),
    .en        (cnt_en),
    .load_zero (cnt_zero),
    .cnt       (cnt)
  );

  always_ff @(posedge clk) begin
    if (!clr && (state == CAPTURE)) begin
      for (int j = 0; j < 5; j++) begin
        row_buf[LAST - cnt][j] <= col_w[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_row   <= 3'd0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int j = 0; j < 5; j++) begin
        res_q[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (drain_start) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (drain_start) begin
            overrun <= 1'b1;
          end
          // Row 0 arrives on the final capture edge, so it goes straight to the lanes.
          if (cnt == LAST) begin
            state     <= OUTPUT;
            res_valid <= 1'b1;
            res_row   <= 3'd0;
            res_q     <= col_w;
          end
        end
        OUTPUT: begin
          if (drain_start && !last_hs) begin
            overrun <= 1'b1;
          end
          if (last_hs) begin
            res_valid <= 1'b0;
            if (drain_start) begin
              state <= CAPTURE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (hs) begin
            res_row <= nxt;
            res_q   <= row_buf[nxt];
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed sequence with random data; expected rows come from the capture order (row DIM-1 first).
module tb_systolic_result_collector;

  localparam int N   = 32;
  localparam int DIM = 5;

  logic         clk = 1'b0;
  logic         clr;
  logic         drain_start;
  logic         res_ready;
  logic [N-1:0] col [5];
  logic         res_valid;
  logic [2:0]   res_row;
  logic [N-1:0] res0, res1, res2, res3, res4;
  logic         busy;
  logic         overrun;
  logic [N-1:0] res_w [5];

  logic [N-1:0] exp_row [DIM][5];
  bit           exp_ovr;
  int           vectors     = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  assign res_w[0] = res0;
  assign res_w[1] = res1;
  assign res_w[2] = res2;
  assign res_w[3] = res3;
  assign res_w[4] = res4;

  systolic_result_collector #(.N(N), .DIM(DIM)) dut (
    .clk         (clk),
    .clr         (clr),
    .drain_start (drain_start),
    .col_in0     (col[0]),
    .col_in1     (col[1]),
    .col_in2     (col[2]),
    .col_in3     (col[3]),
    .col_in4     (col[4]),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_row     (res_row),
    .res0        (res0),
    .res1        (res1),
    .res2        (res2),
    .res3        (res3),
    .res4        (res4),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_cols();
    for (int j = 0; j < 5; j++) col[j] = N'($urandom);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " valid"}, N'(res_valid), '0);
    chk({tag, " row"}, N'(res_row), '0);
    chk({tag, " busy"}, N'(busy), '0);
    chk({tag, " overrun"}, N'(overrun), '0);
    for (int j = 0; j < 5; j++) chk($sformatf("%s lane%0d", tag, j), res_w[j], '0);
  endtask

  task automatic check_row(input int r, input string tag);
    chk($sformatf("%s valid r%0d", tag, r), N'(res_valid), N'(1));
    chk($sformatf("%s row r%0d", tag, r), N'(res_row), N'(r));
    for (int j = 0; j < 5; j++)
      chk($sformatf("%s lane r%0d c%0d", tag, r, j), res_w[j], exp_row[r][j]);
  endtask

  task automatic start();
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    chk("start busy", N'(busy), N'(1));
  endtask

  // Five capture edges; the word presented on capture k belongs to row DIM-1-k.
  task automatic capture(input bit formula, input int ovr_at);
    int r;
    for (int k = 0; k < DIM; k++) begin
      r = DIM - 1 - k;
      for (int j = 0; j < 5; j++) begin
        col[j] = formula ? N'(10 * r + j) : N'($urandom);
        exp_row[r][j] = col[j];
      end
      drain_start = (k == ovr_at);
      if (k == ovr_at) exp_ovr = 1'b1;
      tick();
      chk("cap busy", N'(busy), N'(1));
      if (k < DIM - 1) chk("cap valid", N'(res_valid), '0);
    end
    drain_start = 1'b0;
    chk("cap overrun", N'(overrun), N'(exp_ovr));
  endtask

  task automatic emit(input int stall_row, input int stall_n, input bit b2b, input string tag);
    res_ready = 1'b1;
    for (int r = 0; r < DIM; r++) begin
      check_row(r, tag);
      if (r == stall_row) begin
        res_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          rand_cols();
          tick();
          check_row(r, {tag, " stall"});
        end
        res_ready = 1'b1;
      end
      rand_cols();
      drain_start = (b2b && r == DIM - 1);
      tick();
    end
    drain_start = 1'b0;
    chk({tag, " end valid"}, N'(res_valid), '0);
    chk({tag, " end busy"}, N'(busy), N'(b2b));
    chk({tag, " end overrun"}, N'(overrun), N'(exp_ovr));
    if (!b2b)
      for (int j = 0; j < 5; j++) chk($sformatf("%s hold c%0d", tag, j), res_w[j], exp_row[DIM-1][j]);
  endtask

  initial begin
    clr         = 1'b1;
    drain_start = 1'b0;
    res_ready   = 1'b0;
    exp_ovr     = 1'b0;
    rand_cols();

    // Reset with random inputs on the other pins
    for (int i = 0; i < 2; i++) begin
      drain_start = 1'($urandom);
      res_ready   = 1'($urandom);
      rand_cols();
      tick();
      check_idle_zero("reset");
    end
    clr         = 1'b0;
    drain_start = 1'b0;
    res_ready   = 1'b1;
    tick();
    check_idle_zero("post reset");

    // Basic drain with 10*r+j pattern
    start();
    capture(1'b1, -1);
    chk("basic r0c3", res3, N'(3));
    emit(-1, 0, 1'b0, "basic");

    // Backpressure on row 1
    start();
    capture(1'b1, -1);
    emit(1, 3, 1'b0, "bp");

    // Overrun during capture cycle 2, sticky until clr
    start();
    capture(1'b0, 2);
    emit($urandom_range(0, 4), $urandom_range(0, 2), 1'b0, "ovr");
    tick();
    chk("ovr sticky", N'(overrun), N'(1));
    start();
    capture(1'b0, -1);
    emit(-1, 0, 1'b0, "ovr2");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr cleared", N'(overrun), '0);

    // Back-to-back drains
    start();
    capture(1'b0, -1);
    emit(-1, 0, 1'b1, "b2b1");
    capture(1'b0, -1);
    emit(2, 1, 1'b0, "b2b2");

    // Reset while row 2 is presented
    start();
    capture(1'b0, -1);
    res_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      check_row(r, "midrst");
      tick();
    end
    check_row(2, "midrst");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_idle_zero("midrst clr");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst idle valid", N'(res_valid), '0);
    end
    start();
    capture(1'b0, -1);
    emit(-1, 0, 1'b0, "midrst new");

    // Random drains with random stalls
    for (int i = 0; i < 4; i++) begin
      start();
      capture(1'b0, -1);
      emit($urandom_range(0, 4), $urandom_range(0, 3), 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
